// File: rtl/lfsr_pkg.sv
// Shared definitions for the 28-bit Fibonacci LFSR (x^28 + x^25 + 1).
// Generator and checker both take the polynomial from lfsr_next().
package lfsr_pkg;

    localparam int LFSR_W = 28;
    localparam int TAP_HI = 27;
    localparam int TAP_LO = 24;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } chk_state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], q[TAP_HI] ^ q[TAP_LO]};
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Receive-side LFSR stream checker: self-synchronises, predicts each word,
// and reports lock status with saturating error and word counters.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int WIDTH    = LFSR_W,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] word_count,
    output chk_state_t       state_o
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_CNT - 1);

    chk_state_t         state_q, state_d;
    logic [WIDTH-1:0]   exp_q, exp_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic               pulse_q, pulse_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;

    logic               hit;
    logic               count_err;
    logic               count_word;
    logic [WIDTH-1:0]   exp_step;
    logic [WIDTH-1:0]   word_step;

    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        match_d    = match_q;
        miss_d     = miss_q;
        pulse_d    = 1'b0;
        err_cnt_d  = err_cnt_q;
        word_cnt_d = word_cnt_q;
        count_err  = 1'b0;
        count_word = 1'b0;
        hit        = (in_data == exp_q);
        exp_step   = lfsr_next(exp_q);
        word_step  = lfsr_next(in_data);

        if (in_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_data != '0) begin
                        exp_d   = word_step;
                        match_d = '0;
                        state_d = ST_ACQUIRE;
                    end
                end
                ST_ACQUIRE: begin
                    if (in_data == '0) begin
                        match_d = '0;
                        state_d = ST_IDLE;
                    end else if (hit) begin
                        exp_d = word_step;
                        if (match_q == MATCH_LAST) begin
                            match_d    = '0;
                            miss_d     = '0;
                            count_word = 1'b1;
                            state_d    = ST_LOCKED;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end else begin
                        exp_d   = word_step;
                        match_d = '0;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: the prediction advances from itself, not from the
                    // received word, so isolated bit errors do not corrupt it.
                    count_word = 1'b1;
                    exp_d      = exp_step;
                    if (hit) begin
                        miss_d = '0;
                    end else begin
                        pulse_d   = 1'b1;
                        count_err = 1'b1;
                        if (miss_q == MISS_LAST) begin
                            exp_d   = word_step;
                            match_d = '0;
                            miss_d  = '0;
                            state_d = ST_ACQUIRE;
                        end else begin
                            miss_d = miss_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A clear coinciding with a new error keeps that error.
        if (err_clr) begin
            err_cnt_d = count_err ? CNT_W'(1) : '0;
        end else if (count_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end

        if (count_word && (word_cnt_q != '1)) begin
            word_cnt_d = word_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            exp_q      <= '0;
            match_q    <= '0;
            miss_q     <= '0;
            pulse_q    <= 1'b0;
            err_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            match_q    <= match_d;
            miss_q     <= miss_d;
            pulse_q    <= pulse_d;
            err_cnt_q  <= err_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign locked     = (state_q == ST_LOCKED);
    assign err_pulse  = pulse_q;
    assign err_count  = err_cnt_q;
    assign word_count = word_cnt_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: randomized and directed LFSR streams checked by a
// queue scoreboard against a behavioural model, plus a small-counter instance.
module tb_lfsr_checker;
    import lfsr_pkg::*;

    localparam int LOCK_N = 4;
    localparam int LOSS_N = 8;
    localparam int EW     = 36;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [27:0] in_data = '0;
    logic        err_clr = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [15:0] word_count;
    chk_state_t  state_o;

    logic        sat_reset = 1'b1;
    logic        sat_valid = 1'b0;
    logic [27:0] sat_data = '0;
    logic        sat_locked;
    logic        sat_pulse;
    logic [2:0]  sat_err;
    logic [2:0]  sat_words;
    chk_state_t  sat_state;

    int tests_run = 0;
    int tests_failed = 0;

    logic [EW-1:0] exp_q[$];

    // model state
    chk_state_t  m_phase = ST_IDLE;
    logic [27:0] m_exp = '0;
    int          m_run = 0;
    int          m_miss = 0;
    int unsigned m_err = 0;
    int unsigned m_words = 0;
    logic        m_pulse = 1'b0;

    logic [27:0] gen;

    always #5 clk = ~clk;

    lfsr_checker dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .err_clr(err_clr), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count), .word_count(word_count), .state_o(state_o)
    );

    lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(16), .CNT_W(3)) sat_dut (
        .clk(clk), .reset(sat_reset), .in_valid(sat_valid), .in_data(sat_data),
        .err_clr(1'b0), .locked(sat_locked), .err_pulse(sat_pulse),
        .err_count(sat_err), .word_count(sat_words), .state_o(sat_state)
    );

    function automatic logic [27:0] ref_next(input logic [27:0] q);
        int unsigned v;
        v = 32'(q);
        v = ((v << 1) | (((v >> 27) ^ (v >> 24)) & 32'd1)) & 32'h0FFF_FFFF;
        return 28'(v);
    endfunction

    task automatic model_step(input logic rst, input logic v, input logic [27:0] d,
                              input logic clr);
        logic bad;
        bad = 1'b0;
        m_pulse = 1'b0;
        if (rst) begin
            m_phase = ST_IDLE; m_exp = '0; m_run = 0; m_miss = 0;
            m_err = 0; m_words = 0;
            return;
        end
        if (v) begin
            case (m_phase)
                ST_IDLE: if (d != 0) begin
                    m_exp = ref_next(d); m_run = 0; m_phase = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (d == 0) begin
                        m_phase = ST_IDLE; m_run = 0;
                    end else begin
                        m_run = (d == m_exp) ? m_run + 1 : 0;
                        m_exp = ref_next(d);
                        if (m_run == LOCK_N) begin
                            m_phase = ST_LOCKED; m_run = 0; m_miss = 0;
                            if (m_words < 65535) m_words++;
                        end
                    end
                end
                default: begin
                    if (m_words < 65535) m_words++;
                    if (d == m_exp) begin
                        m_miss = 0; m_exp = ref_next(m_exp);
                    end else begin
                        bad = 1'b1; m_pulse = 1'b1; m_miss++;
                        if (m_miss == LOSS_N) begin
                            m_phase = ST_ACQUIRE; m_run = 0; m_miss = 0; m_exp = ref_next(d);
                        end else begin
                            m_exp = ref_next(m_exp);
                        end
                    end
                end
            endcase
        end
        if (clr) m_err = bad ? 1 : 0;
        else if (bad && m_err < 65535) m_err++;
    endtask

    task automatic drive(input logic rst, input logic v, input logic [27:0] d, input logic clr);
        @(negedge clk);
        reset = rst; in_valid = v; in_data = d; err_clr = clr;
        model_step(rst, v, d, clr);
        exp_q.push_back({m_phase, (m_phase == ST_LOCKED), m_pulse, 16'(m_err), 16'(m_words)});
    endtask

    task automatic send_word(input logic [27:0] d);
        drive(1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic send_clean();
        send_word(gen);
        gen = ref_next(gen);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 28'h0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 28'h0, 1'b0);
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [27:0] rand_mask();
        return 28'($urandom_range(1, 32'h0FFF_FFFF));
    endfunction

    // Scoreboard monitor: one expected item per driven cycle.
    initial begin
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {state_o, locked, err_pulse, err_count, word_count};
                tests_run++;
                if (a !== e) begin
                    tests_failed++;
                    $display("FAIL scoreboard t=%0t: got st=%0d lk=%0b pl=%0b err=%0d wc=%0d, expected st=%0d lk=%0b pl=%0b err=%0d wc=%0d",
                             $time, a[35:34], a[33], a[32], a[31:16], a[15:0],
                             e[35:34], e[33], e[32], e[31:16], e[15:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

    task automatic stream_256(input int gap);
        gen = 28'h1;
        for (int i = 1; i <= 256; i++) begin
            send_clean();
            idle(gap);
            if (i == 4 || i == 5) begin
                sample();
                check(i == 4 ? "no lock before word 5" : "lock at word 5",
                      32'(locked), 32'(i == 5));
            end
        end
        sample();
        check("word_count after 256", 32'(word_count), 32'd252);
        check("err_count after 256", 32'(err_count), 32'd0);
        check("locked after 256", 32'(locked), 32'd1);
    endtask

    task automatic sat_drive(input logic rst, input logic v, input logic [27:0] d);
        @(negedge clk);
        sat_reset = rst; sat_valid = v; sat_data = d;
    endtask

    initial begin
        int pct;
        // reset state
        do_reset(3);
        sample();
        check("reset locked", 32'(locked), 32'd0);
        check("reset err_count", 32'(err_count), 32'd0);
        check("reset word_count", 32'(word_count), 32'd0);

        // clean stream from seed 1
        stream_256(0);

        // single bit-0 flip while locked
        for (int i = 0; i < 10; i++) send_clean();
        send_word(gen ^ 28'h1);
        gen = ref_next(gen);
        sample();
        check("flip err_pulse", 32'(err_pulse), 32'd1);
        check("flip err_count", 32'(err_count), 32'd1);
        check("flip locked", 32'(locked), 32'd1);
        send_clean();
        sample();
        check("flywheel pulse clear", 32'(err_pulse), 32'd0);
        check("flywheel err_count", 32'(err_count), 32'd1);

        // err_clr alone, then 8 corrupted words drop lock
        drive(1'b0, 1'b0, 28'h0, 1'b1);
        sample();
        check("err_clr alone", 32'(err_count), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            send_word(gen ^ rand_mask());
            gen = ref_next(gen);
            if (k >= 7) begin
                sample();
                check(k == 7 ? "locked after 7 misses" : "unlocked after 8 misses",
                      32'(locked), 32'(k == 7));
            end
        end
        check("err_count after 8 misses", 32'(err_count), 32'd8);
        for (int j = 1; j <= 5; j++) begin
            send_clean();
            if (j >= 4) begin
                sample();
                check(j == 4 ? "no relock at 4" : "relock at 5", 32'(locked), 32'(j == 5));
            end
        end

        // 1-of-3 valid duty
        do_reset(2);
        stream_256(2);

        // zero words
        do_reset(2);
        for (int i = 0; i < 5; i++) send_word(28'h0);
        sample();
        check("zeros stay idle", 32'(state_o), 32'(ST_IDLE));
        check("zeros unlocked", 32'(locked), 32'd0);
        gen = rand_mask();
        for (int i = 0; i < 3; i++) send_clean();
        sample();
        check("acquire state", 32'(state_o), 32'(ST_ACQUIRE));
        send_word(28'h0);
        sample();
        check("zero in acquire to idle", 32'(state_o), 32'(ST_IDLE));
        for (int i = 0; i < 5; i++) send_clean();
        sample();
        check("relock after zero", 32'(locked), 32'd1);

        // err_clr with an error, then mid-lock reset
        send_word(gen ^ rand_mask()); gen = ref_next(gen);
        send_word(gen ^ rand_mask()); gen = ref_next(gen);
        drive(1'b0, 1'b1, gen ^ rand_mask(), 1'b1); gen = ref_next(gen);
        sample();
        check("err_clr with error", 32'(err_count), 32'd1);
        check("err_clr pulse", 32'(err_pulse), 32'd1);
        drive(1'b1, 1'b1, gen, 1'b0);
        sample();
        check("midreset locked", 32'(locked), 32'd0);
        check("midreset err", 32'(err_count), 32'd0);
        check("midreset words", 32'(word_count), 32'd0);
        check("midreset state", 32'(state_o), 32'(ST_IDLE));
        gen = 28'h1;
        for (int i = 1; i <= 5; i++) begin
            send_clean();
            if (i >= 4) begin
                sample();
                check("relock after reset", 32'(locked), 32'(i == 5));
            end
        end

        // randomized traffic, scoreboard only
        do_reset(1);
        gen = rand_mask();
        for (int n = 0; n < 2400; n++) begin
            int r;
            case ((n / 300) % 4)
                0: pct = 0;
                1: pct = 5;
                2: pct = 30;
                default: pct = 70;
            endcase
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset(1);
                gen = rand_mask();
            end else if (r < 4) begin
                gen = rand_mask();
            end else if (r < 25) begin
                drive(1'b0, 1'b0, 28'($urandom), ($urandom_range(0, 9) == 0));
            end else if (r < 27) begin
                drive(1'b0, 1'b1, 28'h0, 1'b0);
            end else begin
                logic [27:0] w;
                w = gen;
                if ($urandom_range(0, 99) < pct) w = w ^ rand_mask();
                drive(1'b0, 1'b1, w, ($urandom_range(0, 19) == 0));
                gen = ref_next(gen);
            end
        end
        idle(1);
        for (int t = 0; t < 50 && exp_q.size() > 0; t++) @(posedge clk);
        #2;
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        // saturation on the 3-bit counter instance
        sat_drive(1'b1, 1'b0, 28'h0);
        sat_drive(1'b1, 1'b0, 28'h0);
        gen = 28'h1;
        for (int i = 0; i < 5; i++) begin
            sat_drive(1'b0, 1'b1, gen);
            gen = ref_next(gen);
        end
        sample();
        check("sat locked", 32'(sat_locked), 32'd1);
        check("sat lock word count", 32'(sat_words), 32'd1);
        for (int i = 0; i < 6; i++) begin
            sat_drive(1'b0, 1'b1, gen ^ rand_mask());
            gen = ref_next(gen);
        end
        sample();
        check("sat err before limit", 32'(sat_err), 32'd6);
        check("sat words at limit", 32'(sat_words), 32'd7);
        for (int i = 0; i < 3; i++) begin
            sat_drive(1'b0, 1'b1, gen ^ rand_mask());
            gen = ref_next(gen);
            sample();
            check("sat err holds", 32'(sat_err), 32'd7);
            check("sat pulse", 32'(sat_pulse), 32'd1);
        end
        check("sat words hold", 32'(sat_words), 32'd7);
        check("sat still locked", 32'(sat_locked), 32'd1);
        sat_drive(1'b0, 1'b0, 28'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
